sdbp_frame_reader: RTL and testbench

- Consumer side of the LED frame buffer interface.
- The frame writer fills a 360-entry x 16-bit dual-port RAM through its write port, then raises sdbpflag.
- This block detects the sdbpflag rising edge, reads every entry back through the RAM read port, and serialises each word MSB-first onto the SDBP LED-driver link (sclk/sdo).
- It closes each frame with a latch pulse (le) and a one-cycle frame_done.

---
 rtl/sdbp_pkg.sv | 17 +
 rtl/sdbp_frame_reader_if.sv | 25 ++
 rtl/sdbp_word_shifter.sv | 63 ++++++
 rtl/sdbp_frame_reader.sv | 109 ++++++++++
 tb/tb_sdbp_frame_reader.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/sdbp_pkg.sv
// Shared frame-buffer constants and the reader state encoding, common to
// the SDBP frame writer and reader so frame size and widths stay consistent.
`timescale 1ns/1ps
package sdbp_pkg;
  localparam int LED_NUM = 360;
  localparam int DW      = 16;
  localparam int AW      = 10;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LOAD,
    SHIFT,
    LATCH,
    DONE
  } rd_state_t;
endpackage

// File: rtl/sdbp_frame_reader_if.sv
// Frame buffer read port plus SDBP LED-driver link, seen from the reader
// (master) and from the RAM/driver side (slave).
`timescale 1ns/1ps
interface sdbp_frame_reader_if;
  import sdbp_pkg::*;

  logic          sdbpflag;
  logic [AW-1:0] rdaddr;
  logic [DW-1:0] rddata;
  logic          sclk;
  logic          sdo;
  logic          le;
  logic          busy;
  logic          frame_done;

  modport master (
    input  sdbpflag, rddata,
    output rdaddr, sclk, sdo, le, busy, frame_done
  );

  modport slave (
    output sdbpflag, rddata,
    input  rdaddr, sclk, sdo, le, busy, frame_done
  );
endinterface

// File: rtl/sdbp_word_shifter.sv
// Serialises one DW-bit word MSB-first: each bit is a low then a high sclk
// phase of CLK_DIV cycles; sdo and sclk come straight from flops.
`timescale 1ns/1ps
module sdbp_word_shifter
  import sdbp_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [DW-1:0] i_word,
  output logic          o_sclk,
  output logic          o_sdo,
  output logic          o_word_done
);
  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam int BW = $clog2(DW);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  logic [DW-1:0] r_shreg;
  logic [BW-1:0] r_bit_idx;
  logic [CW-1:0] r_div_cnt;
  logic          r_phase;
  logic          r_active;
  logic          w_tick;

  assign w_tick      = r_active && (r_div_cnt == DIV_LAST);
  assign o_word_done = w_tick && r_phase && (r_bit_idx == '0);
  assign o_sclk      = r_phase;
  // The final shift empties the register, so sdo rests at 0 between words.
  assign o_sdo       = r_shreg[DW-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg   <= '0;
      r_bit_idx <= '0;
      r_div_cnt <= '0;
      r_phase   <= 1'b0;
      r_active  <= 1'b0;
    end else if (i_load) begin
      r_shreg   <= i_word;
      r_bit_idx <= BW'(DW - 1);
      r_div_cnt <= '0;
      r_phase   <= 1'b0;
      r_active  <= 1'b1;
    end else if (r_active) begin
      if (w_tick) begin
        r_div_cnt <= '0;
        if (!r_phase) begin
          r_phase <= 1'b1;
        end else begin
          r_phase   <= 1'b0;
          r_shreg   <= {r_shreg[DW-2:0], 1'b0};
          r_bit_idx <= r_bit_idx - BW'(1);
          if (r_bit_idx == '0) r_active <= 1'b0;
        end
      end else begin
        r_div_cnt <= r_div_cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/sdbp_frame_reader.sv
// Reads a full frame back from the LED frame buffer on an sdbpflag rising
// edge, shifts it out over SDBP, then latches and reports frame_done.
//
//  state | meaning
//  IDLE  | waiting for sdbpflag rising edge
//  ADDR  | RAM samples rdaddr
//  LOAD  | rddata valid, loaded into the shifter
//  SHIFT | word being serialised on sclk/sdo
//  LATCH | le high for LAT_W cycles
//  DONE  | one-cycle frame_done
`timescale 1ns/1ps
module sdbp_frame_reader
  import sdbp_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int LAT_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  sdbp_frame_reader_if.master bus
);
  localparam int LW = $clog2(LAT_W) + 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(LAT_W - 1);
  localparam logic [AW-1:0] LAST_WORD = AW'(LED_NUM - 1);

  rd_state_t     r_state, w_state_nxt;
  logic          r_flag_d;
  logic [AW-1:0] r_rdaddr;
  logic [AW-1:0] r_word_idx;
  logic [LW-1:0] r_lat_cnt;
  logic          r_le, r_busy, r_done;
  logic          w_le_nxt, w_busy_nxt, w_done_nxt;
  logic          w_start, w_load, w_word_done, w_last_word;
  logic          w_sclk, w_sdo;

  assign w_start     = bus.sdbpflag && !r_flag_d && (r_state == IDLE);
  assign w_last_word = (r_word_idx == LAST_WORD);

  sdbp_word_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_word      (bus.rddata),
    .o_sclk      (w_sclk),
    .o_sdo       (w_sdo),
    .o_word_done (w_word_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_start) w_state_nxt = ADDR;
      ADDR:    w_state_nxt = LOAD;
      LOAD:    w_state_nxt = SHIFT;
      SHIFT:   if (w_word_done) w_state_nxt = w_last_word ? LATCH : ADDR;
      LATCH:   if (r_lat_cnt == '0) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are decoded from the next state and then registered.
  always_comb begin
    w_le_nxt   = (w_state_nxt == LATCH);
    w_done_nxt = (w_state_nxt == DONE);
    w_busy_nxt = (w_state_nxt != IDLE);
    w_load     = (r_state == LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag_d   <= 1'b0;
      r_rdaddr   <= '0;
      r_word_idx <= '0;
      r_lat_cnt  <= '0;
      r_le       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_flag_d <= bus.sdbpflag;
      r_le     <= w_le_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      if (w_start) begin
        r_rdaddr   <= '0;
        r_word_idx <= '0;
      end else if ((r_state == SHIFT) && w_word_done && !w_last_word) begin
        r_rdaddr   <= r_word_idx + AW'(1);
        r_word_idx <= r_word_idx + AW'(1);
      end
      if ((w_state_nxt == LATCH) && (r_state != LATCH))
        r_lat_cnt <= LAT_LAST;
      else if ((r_state == LATCH) && (r_lat_cnt != '0))
        r_lat_cnt <= r_lat_cnt - LW'(1);
    end
  end

  assign bus.rdaddr     = r_rdaddr;
  assign bus.sclk       = w_sclk;
  assign bus.sdo        = w_sdo;
  assign bus.le         = r_le;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_done;
endmodule

// File: tb/tb_sdbp_frame_reader.sv
// Bench for sdbp_frame_reader: RAM model, link monitor and a frame-level
// reference (words in address order, MSB-first, fixed frame timing).
`timescale 1ns/1ps
module tb_sdbp_frame_reader;
  import sdbp_pkg::*;

  localparam int CLK_DIV   = 2;
  localparam int LAT_W     = 4;
  localparam int WORD_CYC  = 2 + DW * 2 * CLK_DIV;
  localparam int FRAME_CYC = LED_NUM * WORD_CYC + LAT_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sdbp_frame_reader_if bus();

  sdbp_frame_reader #(.CLK_DIV(CLK_DIV), .LAT_W(LAT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #20 clk = ~clk;

  logic [DW-1:0] mem [LED_NUM];
  always @(posedge clk) bus.rddata <= mem[int'(bus.rdaddr)];

  int   cyc = 0;
  int   fd_cnt = 0, fd_c = 0, le_rises = 0, le_hi = 0;
  int   le_rise_c = 0, le_fall_c = 0, last_fall = 0, sdo_hi_chg = 0;
  logic bits[$];
  logic sclk_q = 1'b0, sdo_q = 1'b0, le_q = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus.sclk && !sclk_q) bits.push_back(bus.sdo);
    if (!bus.sclk && sclk_q) last_fall = cyc;
    if (bus.sclk && sclk_q && (bus.sdo !== sdo_q)) sdo_hi_chg++;
    if (bus.le && !le_q) begin le_rises++; le_rise_c = cyc; end
    if (!bus.le && le_q) le_fall_c = cyc;
    if (bus.le) le_hi++;
    if (bus.frame_done) begin fd_cnt++; fd_c = cyc; end
    sclk_q = bus.sclk;
    sdo_q  = bus.sdo;
    le_q   = bus.le;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    bits.delete();
    fd_cnt = 0;
    le_rises = 0;
    le_hi = 0;
    sdo_hi_chg = 0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (bus.frame_done !== 1'b1 && k < FRAME_CYC + 100) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("%s frame_done seen", tag), bus.frame_done, 1);
  endtask

  // Expected frame: every RAM word in address order, MSB first.
  task automatic eval_frame(input string tag, input int s);
    int bad;
    logic [DW-1:0] w;
    chk($sformatf("%s bit count", tag), bits.size(), LED_NUM * DW);
    bad = LED_NUM;
    if (bits.size() == LED_NUM * DW) begin
      bad = 0;
      for (int i = 0; i < LED_NUM; i++) begin
        w = '0;
        for (int b = 0; b < DW; b++) w = {w[DW-2:0], bits[i*DW+b]};
        if (w !== mem[i]) bad++;
      end
    end
    chk($sformatf("%s bad words", tag), bad, 0);
    chk($sformatf("%s start-to-done", tag), fd_c - s, FRAME_CYC);
    chk($sformatf("%s le pulses", tag), le_rises, 1);
    chk($sformatf("%s le width", tag), le_hi, LAT_W);
    chk($sformatf("%s le rise vs last sclk fall", tag), le_rise_c - last_fall, 0);
    chk($sformatf("%s le fall vs last sclk fall", tag), le_fall_c - last_fall, LAT_W);
    chk($sformatf("%s sdo moved while sclk high", tag), sdo_hi_chg, 0);
    chk($sformatf("%s frame_done count", tag), fd_cnt, 1);
    chk($sformatf("%s busy at done", tag), bus.busy, 1);
    chk($sformatf("%s rdaddr holds last", tag), bus.rdaddr, LED_NUM - 1);
    clear_mon();
  endtask

  initial begin
    int s, k;
    bus.sdbpflag = 1'b0;
    for (int i = 0; i < LED_NUM; i++) mem[i] = DW'(i);

    repeat (3) @(negedge clk);
    chk("reset rdaddr", bus.rdaddr, 0);
    chk("reset sclk", bus.sclk, 0);
    chk("reset sdo", bus.sdo, 0);
    chk("reset le", bus.le, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset frame_done", bus.frame_done, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    clear_mon();

    // Frame 1: ramp data, flag held high well past the end of the frame.
    bus.sdbpflag = 1'b1;
    s = cyc + 1;
    wait_done("f1");
    eval_frame("f1", s);
    repeat (500) @(negedge clk);
    chk("level hold extra frames", fd_cnt, 0);
    chk("level hold busy", bus.busy, 0);
    bus.sdbpflag = 1'b0;

    // Reset in the middle of shifting.
    repeat (3) @(negedge clk);
    bus.sdbpflag = 1'b1;
    repeat ($urandom_range(200, 2000)) @(negedge clk);
    k = 0;
    while (bus.sclk !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    chk("rst reached shift", bus.sclk, 1);
    rst_n = 1'b0;
    bus.sdbpflag = 1'b0;
    #1;
    chk("mid rst rdaddr", bus.rdaddr, 0);
    chk("mid rst sclk", bus.sclk, 0);
    chk("mid rst sdo", bus.sdo, 0);
    chk("mid rst le", bus.le, 0);
    chk("mid rst busy", bus.busy, 0);
    chk("mid rst frame_done", bus.frame_done, 0);
    @(negedge clk);
    clear_mon();
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("post rst le pulses", le_rises, 0);
    chk("post rst frame_done", fd_cnt, 0);
    chk("post rst busy", bus.busy, 0);
    chk("post rst sclk edges", bits.size(), 0);

    // Frame 2: pattern bands plus random words, extra edge at word 100.
    for (int i = 0; i < LED_NUM; i++) begin
      if (i < 90)       mem[i] = 16'hFFFF;
      else if (i < 180) mem[i] = 16'h0000;
      else if (i < 270) mem[i] = 16'hA5A5;
      else              mem[i] = DW'($urandom);
    end
    clear_mon();
    bus.sdbpflag = 1'b1;
    s = cyc + 1;
    k = 0;
    while (bus.rdaddr !== AW'(100) && k < FRAME_CYC) begin @(negedge clk); k++; end
    chk("f2 reached word 100", bus.rdaddr, 100);
    bus.sdbpflag = 1'b0;
    @(negedge clk);
    bus.sdbpflag = 1'b1;
    repeat (10) @(negedge clk);
    bus.sdbpflag = 1'b0;
    wait_done("f2");
    eval_frame("f2", s);

    // Frame 3 starts from the edge sampled in the cycle right after DONE.
    @(negedge clk);
    chk("b2b idle busy", bus.busy, 0);
    bus.sdbpflag = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    chk("b2b rdaddr", bus.rdaddr, 0);
    chk("b2b busy", bus.busy, 1);
    repeat (10) @(negedge clk);
    bus.sdbpflag = 1'b0;
    wait_done("f3");
    eval_frame("f3", s);
    repeat (200) @(negedge clk);
    chk("after f3 extra frames", fd_cnt, 0);
    chk("after f3 busy", bus.busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
